// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for the bit-serial subtractor.
// The master side supplies operands and consumes the result.
interface serial_subtractor_if #(
    parameter int unsigned W = 4
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bi;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         bo;
    logic         ovf;
    logic         zero;

    modport master (
        output in_valid, a, b, bi, out_ready,
        input  in_ready, out_valid, diff, bo, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, bi, out_ready,
        output in_ready, out_valid, diff, bo, ovf, zero
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b - bi, one bit per clock,
// LSB first, with a single borrow flop and valid/ready handshakes on both sides.
module serial_subtractor #(
    parameter int unsigned W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    serial_subtractor_if.slave     bus
);
    localparam int unsigned CW = $clog2(W + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         r_state;
    logic [CW-1:0]  r_cnt;
    logic [W-1:0]   r_a;
    logic [W-1:0]   r_b;
    logic [W-2:0]   r_acc;
    logic           r_br;
    logic           r_a_msb;
    logic           r_b_msb;
    logic [W-1:0]   r_diff;
    logic           r_bo;
    logic           r_ovf;
    logic           r_zero;
    logic           r_in_ready;
    logic           r_out_valid;

    logic           w_d;
    logic           w_br_next;
    logic [W-1:0]   w_diff_next;

    // One full-subtractor cell applied to the current LSBs of the operand shifters.
    assign w_d         = r_a[0] ^ r_b[0] ^ r_br;
    assign w_br_next   = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);
    assign w_diff_next = {w_d, r_acc};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_acc       <= '0;
            r_br        <= 1'b0;
            r_a_msb     <= 1'b0;
            r_b_msb     <= 1'b0;
            r_diff      <= '0;
            r_bo        <= 1'b0;
            r_ovf       <= 1'b0;
            r_zero      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_a        <= bus.a;
                        r_b        <= bus.b;
                        r_br       <= bus.bi;
                        r_a_msb    <= bus.a[W-1];
                        r_b_msb    <= bus.b[W-1];
                        r_acc      <= '0;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_br  <= w_br_next;
                    r_acc <= (W-1)'(w_diff_next >> 1);
                    // Last bit: publish the result and flags together.
                    if (r_cnt == CW'(W - 1)) begin
                        r_diff      <= w_diff_next;
                        r_bo        <= w_br_next;
                        r_ovf       <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
                        r_zero      <= (w_diff_next == '0);
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.diff      = r_diff;
    assign bus.bo        = r_bo;
    assign bus.ovf       = r_ovf;
    assign bus.zero      = r_zero;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed scoreboard bench for serial_subtractor (W=4): stimulus pushes expected
// results, a negedge monitor pops and compares on every output handshake.
module tb_serial_subtractor;
    localparam int unsigned W   = 4;
    localparam int          TMO = 20;

    typedef struct packed {
        logic [W-1:0] diff;
        logic         bo;
        logic         ovf;
        logic         zero;
    } res_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    serial_subtractor_if #(.W(W)) bus ();
    serial_subtractor #(.W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    res_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic res_t mk(input logic [W-1:0] d, input logic bo, input logic ovf, input logic z);
        res_t r;
        r.diff = d; r.bo = bo; r.ovf = ovf; r.zero = z;
        return r;
    endfunction

    // Monitor: compare every accepted result against the oldest expectation.
    res_t mon_e;
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got diff %0h with empty scoreboard", bus.diff);
            end else begin
                mon_e = exp_q.pop_front();
                check("result{diff,bo,ovf,zero}", 32'({bus.diff, bus.bo, bus.ovf, bus.zero}), 32'(mon_e));
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!bus.in_ready && n < TMO) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_wait", 32'(bus.in_ready), 32'd1);
    endtask

    // Issue one operation; leaves time at #1 after the edge where out_valid is first seen.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                        input res_t e, input bit hold);
        int n = 0;
        @(negedge clk);
        wait_ready();
        bus.a = a; bus.b = b; bus.bi = bi; bus.in_valid = 1'b1;
        exp_q.push_back(e);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        while (!bus.out_valid && n < TMO) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("latency", 32'(n), 32'(W));
        if (!hold) begin
            @(posedge clk);
            #1 check("valid_one_cycle", 32'(bus.out_valid), 32'd0);
        end
    endtask

    initial begin
        bit seen;
        res_t e;
        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.bi = 1'b0; bus.out_ready = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_outputs", 32'({bus.diff, bus.bo, bus.ovf, bus.zero}), 32'd0);
        rst = 1'b0;

        // Hand-computed: ovf per the MSB rule on the original operands.
        send(4'h9, 4'h3, 1'b0, mk(4'h6, 1'b0, 1'b1, 1'b0), 1'b0);
        send(4'h3, 4'h9, 1'b0, mk(4'hA, 1'b1, 1'b1, 1'b0), 1'b0);
        send(4'h7, 4'h8, 1'b0, mk(4'hF, 1'b1, 1'b1, 1'b0), 1'b0);
        send(4'h5, 4'h4, 1'b1, mk(4'h0, 1'b0, 1'b0, 1'b1), 1'b0);
        send(4'h0, 4'hF, 1'b1, mk(4'h0, 1'b1, 1'b0, 1'b1), 1'b0);
        send(4'h0, 4'h0, 1'b1, mk(4'hF, 1'b1, 1'b0, 1'b0), 1'b0);
        send(4'h8, 4'h1, 1'b0, mk(4'h7, 1'b0, 1'b1, 1'b0), 1'b0);
        send(4'hF, 4'hF, 1'b0, mk(4'h0, 1'b0, 1'b0, 1'b1), 1'b0);

        // Backpressure: result must hold and stray in_valid must be ignored.
        bus.out_ready = 1'b0;
        e = mk(4'h4, 1'b0, 1'b0, 1'b0);
        send(4'h6, 4'h2, 1'b0, e, 1'b1);
        for (int i = 0; i < 5; i++) begin
            check("bp_out_valid", 32'(bus.out_valid), 32'd1);
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
            check("bp_hold", 32'({bus.diff, bus.bo, bus.ovf, bus.zero}), 32'(e));
            if (i == 2) begin
                bus.a = 4'h1; bus.b = 4'h1; bus.bi = 1'b0; bus.in_valid = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_valid", 32'(bus.out_valid), 32'd0);
        check("bp_release_ready", 32'(bus.in_ready), 32'd1);
        send(4'hC, 4'h5, 1'b0, mk(4'h7, 1'b0, 1'b1, 1'b0), 1'b0);

        // Reset asserted on the 2nd BUSY edge aborts the operation.
        @(negedge clk);
        wait_ready();
        bus.a = 4'h9; bus.b = 4'h3; bus.bi = 1'b0; bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("abort_in_ready", 32'(bus.in_ready), 32'd1);
        check("abort_out_valid", 32'(bus.out_valid), 32'd0);
        check("abort_outputs", 32'({bus.diff, bus.bo, bus.ovf, bus.zero}), 32'd0);
        seen = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1 if (bus.out_valid) seen = 1'b1;
        end
        check("abort_no_result", 32'(seen), 32'd0);
        send(4'h9, 4'h3, 1'b0, mk(4'h6, 1'b0, 1'b1, 1'b0), 1'b0);

        repeat (3) @(posedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
